// File: rtl/mcp3201_pkg.sv
// Shared types and constants for the MCP3201 pin-side emulator.
package mcp3201_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    DATA,
    TAIL,
    ZERO
  } state_t;

  localparam int NULL_FALL = 2;
  localparam int MSB_FALL  = 3;
  localparam int FCNT_W    = 6;

endpackage

// File: rtl/mcp3201_emu_sync.sv
// Multi-flop synchronizer with edge strobes for one asynchronous pin.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Resetting to 0 means a CS_n already low at reset release never yields a fall,
  // so a frame in flight is ignored until CS_n cycles high and low again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/mcp3201_emu.sv
// MCP3201 SPI responder, oversampled in the clk domain.
// Define MCP3201_LSB_TAIL_EN to append the LSB-first tail after B0.
import mcp3201_pkg::*;

module mcp3201_emu #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_used,
  input  logic              clk_pin,
  input  logic              cs_pin_n,
  output logic              dout_pin,
  output logic              dout_oe,
  output logic              frame_active,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam logic [FCNT_W-1:0] B0_FALL = FCNT_W'(MSB_FALL + DATA_W - 1);
`ifdef MCP3201_LSB_TAIL_EN
  localparam logic [FCNT_W-1:0] TAIL_LAST = FCNT_W'(2 * DATA_W + 1);
`endif

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst_n(rst_n), .pin(clk_pin),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst_n(rst_n), .pin(cs_pin_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  state_t            state, state_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt, fcnt_inc, pos;
  logic [DATA_W-1:0] hold, shreg, bit_sel;
  logic              b0_seen, b0_nxt, load;
  logic              dout_nxt, oe_nxt, fa_nxt, used_nxt, done_nxt, abort_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold <= '0;
    else if (sample_valid) hold <= sample_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fcnt         <= '0;
      b0_seen      <= 1'b0;
      shreg        <= '0;
      dout_pin     <= 1'b0;
      dout_oe      <= 1'b0;
      frame_active <= 1'b0;
      sample_used  <= 1'b0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
    end else begin
      state        <= state_nxt;
      fcnt         <= fcnt_nxt;
      b0_seen      <= b0_nxt;
      dout_pin     <= dout_nxt;
      dout_oe      <= oe_nxt;
      frame_active <= fa_nxt;
      sample_used  <= used_nxt;
      frame_done   <= done_nxt;
      frame_abort  <= abort_nxt;
      if (load) shreg <= sample_valid ? sample_data : hold;
    end
  end

  // One bit index serves both directions: MSB-first down to B0, then LSB-first back up.
  assign fcnt_inc = (fcnt == '1) ? fcnt : fcnt + 1'b1;
  assign pos      = (fcnt_inc > B0_FALL) ? fcnt_inc - B0_FALL : B0_FALL - fcnt_inc;
  assign bit_sel  = shreg >> pos;

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    b0_nxt    = b0_seen;
    dout_nxt  = dout_pin;
    oe_nxt    = dout_oe;
    fa_nxt    = frame_active;
    used_nxt  = 1'b0;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    load      = 1'b0;
    if (state == IDLE) begin
      oe_nxt   = 1'b0;
      dout_nxt = 1'b0;
      if (cs_fall) begin
        load      = 1'b1;
        used_nxt  = 1'b1;
        fcnt_nxt  = '0;
        b0_nxt    = 1'b0;
        fa_nxt    = 1'b1;
        state_nxt = SAMPLE;
      end
    end else if (cs_rise) begin
      state_nxt = IDLE;
      oe_nxt    = 1'b0;
      dout_nxt  = 1'b0;
      fa_nxt    = 1'b0;
      done_nxt  = b0_seen;
      abort_nxt = ~b0_seen;
    end else if (!cs_lvl) begin
      if (sclk_rise && fcnt >= B0_FALL) b0_nxt = 1'b1;
      if (sclk_fall) begin
        fcnt_nxt = fcnt_inc;
        case (state)
          SAMPLE: begin
            if (fcnt_inc == FCNT_W'(NULL_FALL)) begin
              oe_nxt    = 1'b1;
              dout_nxt  = 1'b0;
              state_nxt = DATA;
            end
          end
          DATA: begin
            if (fcnt_inc <= B0_FALL) begin
              dout_nxt = bit_sel[0];
            end else begin
`ifdef MCP3201_LSB_TAIL_EN
              dout_nxt  = bit_sel[0];
              state_nxt = TAIL;
`else
              dout_nxt  = 1'b0;
              state_nxt = ZERO;
`endif
            end
          end
`ifdef MCP3201_LSB_TAIL_EN
          TAIL: begin
            if (fcnt_inc <= TAIL_LAST) begin
              dout_nxt = bit_sel[0];
            end else begin
              dout_nxt  = 1'b0;
              state_nxt = ZERO;
            end
          end
`endif
          ZERO:    dout_nxt = 1'b0;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp3201_emu.sv
// Directed bench for mcp3201_emu: an SPI master model reads frames bit by bit.
module tb_mcp3201_emu;

  localparam int HP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_used;
  logic        clk_pin;
  logic        cs_pin_n;
  logic        dout_pin;
  logic        dout_oe;
  logic        frame_active;
  logic        frame_done;
  logic        frame_abort;

  mcp3201_emu dut (
    .clk(clk), .rst_n(rst_n),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_used(sample_used),
    .clk_pin(clk_pin), .cs_pin_n(cs_pin_n),
    .dout_pin(dout_pin), .dout_oe(dout_oe),
    .frame_active(frame_active), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_done = 0, n_abort = 0, n_used = 0;
  int d0, a0, u0;
  logic bits [0:31];
  logic oes  [0:31];
  logic end_dout, end_oe, fa_mid;

  always @(negedge clk) begin
    if (frame_done)  n_done  <= n_done + 1;
    if (frame_abort) n_abort <= n_abort + 1;
    if (sample_used) n_used  <= n_used + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic snap();
    d0 = n_done; a0 = n_abort; u0 = n_used;
  endtask

  // CS fall, then ncyc SCLK cycles (rise then fall); bit k is read just before rise k+1.
  task automatic run_frame(input int ncyc, input bit byp, input logic [11:0] bd);
    cs_pin_n = 1'b0;
    if (byp) begin
      tick(2);
      sample_data  = bd;
      sample_valid = 1'b1;
      tick(1);
      sample_valid = 1'b0;
      tick(5);
    end else begin
      tick(8);
    end
    fa_mid = frame_active;
    for (int k = 0; k < ncyc; k++) begin
      bits[k] = dout_pin;
      oes[k]  = dout_oe;
      clk_pin = 1'b1;
      tick(HP);
      clk_pin = 1'b0;
      tick(HP);
    end
    end_dout = dout_pin;
    end_oe   = dout_oe;
  endtask

  task automatic close_check(input string tag);
    cs_pin_n = 1'b1;
    tick(2);
    check({tag, "_oe_hold"}, dout_oe, 1'b1);
    tick(1);
    check({tag, "_oe_off"}, dout_oe, 1'b0);
    check({tag, "_fa_off"}, frame_active, 1'b0);
    check({tag, "_dout_off"}, dout_pin, 1'b0);
    tick(6);
  endtask

  function automatic logic [11:0] word();
    logic [11:0] w;
    for (int i = 0; i < 12; i++) w[11-i] = bits[3+i];
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; sample_data = '0;
    clk_pin = 1'b0; cs_pin_n = 1'b1;
    tick(3);
    check("rst_dout", dout_pin, 1'b0);
    check("rst_oe", dout_oe, 1'b0);
    check("rst_fa", frame_active, 1'b0);
    check("rst_pulses", {sample_used, frame_done, frame_abort}, 3'b000);
    rst_n = 1'b1;
    tick(5);

    // basic frame
    load(12'hA5C);
    snap();
    run_frame(15, 1'b0, 12'h0);
    check("t1_fa_mid", fa_mid, 1'b1);
    check("t1_null", bits[2], 1'b0);
    check("t1_oe_pre", oes[1], 1'b0);
    check("t1_oe_null", oes[2], 1'b1);
    check("t1_word", word(), 12'hA5C);
    check("t1_end_oe", end_oe, 1'b1);
    check("t1_end_dout", end_dout, 1'b0);
    close_check("t1");
    check("t1_done", n_done - d0, 1);
    check("t1_abort", n_abort - a0, 0);
    check("t1_used", n_used - u0, 1);

    // short frame aborts
    snap();
    run_frame(6, 1'b0, 12'h0);
    close_check("t2");
    check("t2_abort", n_abort - a0, 1);
    check("t2_done", n_done - d0, 0);

    // sample_valid coincident with detected CS fall
    load(12'h111);
    snap();
    run_frame(15, 1'b1, 12'h3F0);
    check("t3_word", word(), 12'h3F0);
    close_check("t3");
    check("t3_used", n_used - u0, 1);
    check("t3_done", n_done - d0, 1);

    // SCLK activity with CS high
    snap();
    for (int k = 0; k < 20; k++) begin
      clk_pin = 1'b1; tick(HP);
      clk_pin = 1'b0; tick(HP);
    end
    check("t4_oe_idle", dout_oe, 1'b0);
    check("t4_fa_idle", frame_active, 1'b0);
    check("t4_pulses", (n_done - d0) + (n_abort - a0) + (n_used - u0), 0);
    load(12'h0FF);
    snap();
    run_frame(15, 1'b0, 12'h0);
    check("t4_word", word(), 12'h0FF);
    close_check("t4");
    check("t4_done", n_done - d0, 1);

`ifdef MCP3201_LSB_TAIL_EN
    begin
      logic [10:0] t;
      load(12'h801);
      snap();
      run_frame(26, 1'b0, 12'h0);
      for (int i = 0; i < 11; i++) t[i] = bits[15+i];
      check("t5_word", word(), 12'h801);
      check("t5_tail", t, 11'h400);
      check("t5_end_dout", end_dout, 1'b0);
      close_check("t5");
      check("t5_done", n_done - d0, 1);
    end
`endif

    // asynchronous reset during B6
    load(12'h0C0);
    cs_pin_n = 1'b0;
    tick(8);
    for (int k = 0; k < 8; k++) begin
      clk_pin = 1'b1; tick(HP);
      clk_pin = 1'b0; tick(HP);
    end
    check("t6_oe_b6", dout_oe, 1'b1);
    check("t6_dout_b6", dout_pin, 1'b1);
    rst_n = 1'b0;
    #2;
    check("t6_oe_async", dout_oe, 1'b0);
    check("t6_fa_async", frame_active, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    snap();
    for (int k = 0; k < 5; k++) begin
      clk_pin = 1'b1; tick(HP);
      check("t6_oe_quiet", dout_oe, 1'b0);
      clk_pin = 1'b0; tick(HP);
    end
    check("t6_fa_quiet", frame_active, 1'b0);
    cs_pin_n = 1'b1;
    tick(8);
    check("t6_no_pulse", (n_done - d0) + (n_abort - a0) + (n_used - u0), 0);
    run_frame(15, 1'b0, 12'h0);
    check("t6_word", word(), 12'h000);
    close_check("t6");
    check("t6_done", n_done - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
